fuzz_response_checker: RTL and testbench

- Response-side companion to the fuzz stimulus testbenches. It receives the 350-bit `y` output of a reference (pre-synthesis) top and of a synthesized top, both driven by the same stimulus.
- Each valid cycle it compares the two words and folds each one into its own 32-bit MISR signature.
- It reports pass/fail, the mismatch count and the first failing cycle.
- It replaces per-cycle `$strobe` dumping and post-run diffing for equivalence runs.

---
 rtl/fuzz_chk_pkg.sv | 21 ++
 rtl/fuzz_response_checker_misr.sv | 34 +++
 rtl/fuzz_response_checker.sv | 144 ++++++++++++++
 tb/tb_fuzz_response_checker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_chk_pkg.sv
// Shared constants and types for the fuzz response checker: MISR polynomial
// and seed, run-state encoding, and the fold-slice count for a 350-bit word.
package fuzz_chk_pkg;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of MISR-wide slices needed to cover a word (top slice zero-padded).
  function automatic int fold_slices(input int y_w, input int misr_w);
    return (y_w + misr_w - 1) / misr_w;
  endfunction

  localparam int FOLD_SLICES = fold_slices(350, 32);

endpackage

// File: rtl/fuzz_response_checker_misr.sv
// One combinational MISR step: XOR-fold the input word into a signature-wide
// value, shift the signature through the polynomial, and mix the fold in.
module resp_misr
  import fuzz_chk_pkg::*;
#(
  parameter int Y_W    = 350,
  parameter int MISR_W = 32
) (
  input  logic [MISR_W-1:0] sig,
  input  logic [Y_W-1:0]    y,
  output logic [MISR_W-1:0] next_sig
);

  localparam int SLICES = fold_slices(Y_W, MISR_W);
  localparam logic [MISR_W-1:0] POLY = MISR_W'(MISR_POLY);

  logic [SLICES*MISR_W-1:0] y_pad;
  logic [MISR_W-1:0]        fold;
  logic [MISR_W-1:0]        shifted;

  // Zero-extend so the top partial slice folds in with zeros above bit Y_W-1.
  assign y_pad = (SLICES*MISR_W)'(y);

  // XOR-fold all slices, then apply the Galois shift and mix the fold in.
  always_comb begin
    fold = '0;
    for (int i = 0; i < SLICES; i++) begin
      fold = fold ^ y_pad[i*MISR_W +: MISR_W];
    end
    shifted  = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? POLY : '0);
    next_sig = shifted ^ fold;
  end

endmodule

// File: rtl/fuzz_response_checker.sv
// Equivalence checker for a reference and a synthesized top: compares the two
// output words on every valid sample, signs each with its own MISR, and keeps
// the mismatch count and the first failing sample index.
module fuzz_response_checker
  import fuzz_chk_pkg::*;
#(
  parameter int               Y_W        = 350,
  parameter int               MISR_W     = 32,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = {CNT_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              valid,
  input  logic [Y_W-1:0]    y_ref,
  input  logic [Y_W-1:0]    y_dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_fail_cycle,
  output logic [MISR_W-1:0] sig_ref,
  output logic [MISR_W-1:0] sig_dut
);

  localparam logic [MISR_W-1:0] SEED     = MISR_W'(MISR_SEED);
  localparam logic [CNT_W-1:0]  CNT_ONES = {CNT_W{1'b1}};

  state_t state, state_next;

  logic              sample;
  logic              clear;
  logic              differ;
  logic              hit_max;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cnt_upd;
  logic [CNT_W-1:0]  mm_upd;
  logic [CNT_W-1:0]  ff_upd;
  logic [MISR_W-1:0] sig_ref_step;
  logic [MISR_W-1:0] sig_dut_step;
  logic [MISR_W-1:0] sig_ref_upd;
  logic [MISR_W-1:0] sig_dut_upd;
  logic              pass_upd;

  resp_misr #(.Y_W(Y_W), .MISR_W(MISR_W)) u_misr_ref (
    .sig      (sig_ref),
    .y        (y_ref),
    .next_sig (sig_ref_step)
  );

  resp_misr #(.Y_W(Y_W), .MISR_W(MISR_W)) u_misr_dut (
    .sig      (sig_dut),
    .y        (y_dut),
    .next_sig (sig_dut_step)
  );

  // Sample qualification and next values of every result register.
  always_comb begin
    sample  = (state == RUN) && valid;
    clear   = (state != RUN) && start;
    differ  = (y_ref != y_dut);
    cnt_inc = cycle_count + 1'b1;
    hit_max = sample && (cnt_inc == MAX_CYCLES);

    cnt_upd     = cycle_count;
    mm_upd      = mismatch_count;
    ff_upd      = first_fail_cycle;
    sig_ref_upd = sig_ref;
    sig_dut_upd = sig_dut;
    if (sample) begin
      cnt_upd     = cnt_inc;
      sig_ref_upd = sig_ref_step;
      sig_dut_upd = sig_dut_step;
      if (differ) begin
        if (mismatch_count != CNT_ONES) begin
          mm_upd = mismatch_count + 1'b1;
        end
        if (first_fail_cycle == CNT_ONES) begin
          ff_upd = cycle_count;
        end
      end
    end
    // Includes the sample folded on the closing edge itself.
    pass_upd = (mm_upd == '0) && (sig_ref_upd == sig_dut_upd);
  end

  // Run-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start wins over stop outside RUN, and start is ignored in RUN.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop || hit_max) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Registered status flags, counters and signatures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      cycle_count      <= '0;
      mismatch_count   <= '0;
      first_fail_cycle <= CNT_ONES;
      sig_ref          <= SEED;
      sig_dut          <= SEED;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (clear) begin
        pass             <= 1'b0;
        cycle_count      <= '0;
        mismatch_count   <= '0;
        first_fail_cycle <= CNT_ONES;
        sig_ref          <= SEED;
        sig_dut          <= SEED;
      end else begin
        cycle_count      <= cnt_upd;
        mismatch_count   <= mm_upd;
        first_fail_cycle <= ff_upd;
        sig_ref          <= sig_ref_upd;
        sig_dut          <= sig_dut_upd;
        if ((state == RUN) && (state_next == DONE)) begin
          pass <= pass_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_fuzz_response_checker.sv
// Directed bench for fuzz_response_checker: a behavioural model predicts every
// register after each edge, the prediction is queued when stimulus is driven
// and popped for comparison once the edge has happened.
module tb_fuzz_response_checker;

  localparam int          YW   = 350;
  localparam logic [15:0] MAXC = 16'd8;

  logic            clk;
  logic            rst;
  logic            start;
  logic            stop;
  logic            valid;
  logic [YW-1:0]   y_ref;
  logic [YW-1:0]   y_dut;
  logic            busy;
  logic            done;
  logic            pass;
  logic [15:0]     cycle_count;
  logic [15:0]     mismatch_count;
  logic [15:0]     first_fail_cycle;
  logic [31:0]     sig_ref;
  logic [31:0]     sig_dut;

  fuzz_response_checker #(
    .Y_W(YW), .MISR_W(32), .CNT_W(16), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .done(done), .pass(pass),
    .cycle_count(cycle_count), .mismatch_count(mismatch_count),
    .first_fail_cycle(first_fail_cycle), .sig_ref(sig_ref), .sig_dut(sig_dut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] mm;
    logic [15:0] ff;
    logic [31:0] sr;
    logic [31:0] sd;
    logic        busy;
    logic        done;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Model state: 0 idle, 1 run, 2 done.
  int          m_state;
  logic [15:0] m_cnt, m_mm, m_ff;
  logic [31:0] m_sr, m_sd;
  logic        m_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference of the signature update.
  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [YW-1:0] y);
    logic [31:0] f;
    logic        msb;
    f = 32'h0;
    for (int i = 0; i < YW; i++) f[i % 32] = f[i % 32] ^ y[i];
    msb = s[31];
    s   = s << 1;
    if (msb) s = s ^ 32'h04C11DB7;
    return s ^ f;
  endfunction

  function automatic logic [YW-1:0] rand_y();
    logic [351:0] t;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
    return t[YW-1:0];
  endfunction

  task automatic model_clear();
    m_cnt = 16'h0; m_mm = 16'h0; m_ff = 16'hFFFF;
    m_sr = 32'hFFFFFFFF; m_sd = 32'hFFFFFFFF; m_pass = 1'b0;
  endtask

  task automatic step(input logic s, input logic p, input logic v,
                      input logic [YW-1:0] yr, input logic [YW-1:0] yd);
    exp_t e;
    logic hit;
    start = s; stop = p; valid = v; y_ref = yr; y_dut = yd;
    hit = 1'b0;
    if (m_state == 1) begin
      if (v) begin
        m_sr = mstep(m_sr, yr);
        m_sd = mstep(m_sd, yd);
        if (yr != yd) begin
          if (m_mm != 16'hFFFF) m_mm = m_mm + 16'd1;
          if (m_ff == 16'hFFFF) m_ff = m_cnt;
        end
        m_cnt = m_cnt + 16'd1;
        hit = (m_cnt == MAXC);
      end
      if (p || hit) begin
        m_state = 2;
        m_pass  = (m_mm == 16'h0) && (m_sr == m_sd);
      end
    end else if (s) begin
      model_clear();
      m_state = 1;
    end
    e.cnt = m_cnt; e.mm = m_mm; e.ff = m_ff; e.sr = m_sr; e.sd = m_sd;
    e.busy = (m_state == 1); e.done = (m_state == 2); e.pass = m_pass;
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("cycle_count", 64'(cycle_count), 64'(e.cnt));
    chk("mismatch_count", 64'(mismatch_count), 64'(e.mm));
    chk("first_fail_cycle", 64'(first_fail_cycle), 64'(e.ff));
    chk("sig_ref", 64'(sig_ref), 64'(e.sr));
    chk("sig_dut", 64'(sig_dut), 64'(e.sd));
    chk("busy", 64'(busy), 64'(e.busy));
    chk("done", 64'(done), 64'(e.done));
    if (e.done) chk("pass", 64'(pass), 64'(e.pass));
    start = 1'b0; stop = 1'b0; valid = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_cnt"}, 64'(cycle_count), 64'd0);
    chk({tag, "_mm"}, 64'(mismatch_count), 64'd0);
    chk({tag, "_ff"}, 64'(first_fail_cycle), 64'hFFFF);
    chk({tag, "_sr"}, 64'(sig_ref), 64'hFFFFFFFF);
    chk({tag, "_sd"}, 64'(sig_dut), 64'hFFFFFFFF);
  endtask

  initial begin
    logic [YW-1:0] yr, yd, flip, zero;
    logic [5:0]    pat;
    zero = '0;
    flip = '0;
    flip[YW-1] = 1'b1;
    rst = 1'b1; start = 1'b0; stop = 1'b0; valid = 1'b0;
    y_ref = '0; y_dut = '0;
    m_state = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_values("reset");

    // Zero data, one sample.
    step(1, 0, 0, zero, zero);
    step(0, 0, 1, zero, zero);
    step(0, 1, 0, zero, zero);
    chk("t1_sig_ref_const", 64'(sig_ref), 64'hFB3EE249);
    chk("t1_sig_dut_const", 64'(sig_dut), 64'hFB3EE249);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_ff", 64'(first_fail_cycle), 64'hFFFF);

    // Two mismatches at samples 2 and 5 on bit 349.
    step(1, 0, 0, zero, zero);
    for (int n = 0; n < 6; n++) begin
      yr = rand_y();
      yd = (n == 2 || n == 5) ? (yr ^ flip) : yr;
      step(0, 0, 1, yr, yd);
    end
    step(0, 1, 0, zero, zero);
    chk("t2_mm", 64'(mismatch_count), 64'd2);
    chk("t2_ff", 64'(first_fail_cycle), 64'd2);
    chk("t2_pass", 64'(pass), 64'd0);
    chk("t2_sigs_differ", 64'(sig_ref != sig_dut), 64'd1);

    // Valid gaps: 1,0,0,1,0,1.
    pat = 6'b101001;
    step(1, 0, 0, zero, zero);
    for (int i = 0; i < 6; i++) begin
      yr = rand_y();
      step(0, 0, pat[i], yr, yr);
    end
    step(0, 1, 0, zero, zero);
    chk("t3_cnt", 64'(cycle_count), 64'd3);
    chk("t3_pass", 64'(pass), 64'd1);

    // Auto-stop after MAXC samples; later samples and stop in DONE ignored.
    step(1, 0, 0, zero, zero);
    for (int i = 0; i < 12; i++) begin
      yr = rand_y();
      step(0, 0, 1, yr, yr);
    end
    chk("t4_cnt", 64'(cycle_count), 64'd8);
    step(0, 1, 0, zero, zero);
    chk("t4_done_hold", 64'(done), 64'd1);

    // Stop together with the third sample, then restart from DONE.
    step(1, 0, 0, zero, zero);
    for (int i = 0; i < 3; i++) begin
      yr = rand_y();
      yd = (i == 1) ? rand_y() : yr;
      step(0, (i == 2), 1, yr, yd);
    end
    chk("t5_cnt", 64'(cycle_count), 64'd3);
    chk("t5_done", 64'(done), 64'd1);
    step(1, 0, 0, zero, zero);
    chk("t5_restart_cnt", 64'(cycle_count), 64'd0);
    chk("t5_restart_sig", 64'(sig_ref), 64'hFFFFFFFF);
    chk("t5_restart_done", 64'(done), 64'd0);

    // Asynchronous reset between edges mid-run.
    for (int i = 0; i < 2; i++) begin
      yr = rand_y();
      step(0, 0, 1, yr, rand_y());
    end
    #2 rst = 1'b1;
    #1 chk_reset_values("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    m_state = 0;
    model_clear();

    // In IDLE, start and stop together still enter RUN.
    step(1, 1, 0, zero, zero);
    chk("t6_busy", 64'(busy), 64'd1);
    yr = rand_y();
    step(0, 0, 1, yr, yr);
    step(0, 1, 0, zero, zero);
    chk("t6_pass", 64'(pass), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
